// File: rtl/cache_fill_fsm.sv
// L1 miss handler: latches the block address, streams WORDS in-order reads to main memory, writes each return into the data array.
// Requests start the cycle after the miss is seen; responses are never stalled, gaps in memory_data_valid simply extend the fill.
module cache_fill_fsm #(
    parameter int WORDS = 8,
    parameter int OFF_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] fill_address,
    output logic [15:0] fill_data,
    output logic        write_tag_array
);
    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    localparam int LAST_I = WORDS - 1;
    localparam int MASK_I = (1 << (OFF_W + 1)) - 1;
    localparam logic [OFF_W:0]   REQ_DONE = WORDS[OFF_W:0];
    localparam logic [OFF_W-1:0] RSP_LAST = LAST_I[OFF_W-1:0];
    localparam logic [15:0]      OFF_MASK = MASK_I[15:0];

    state_t           state_q, state_d;
    logic [15:0]      base_q, base_d;
    logic [OFF_W:0]   req_cnt_q, req_cnt_d;
    logic [OFF_W-1:0] rsp_cnt_q, rsp_cnt_d;

    // Everything below is decoded from the registered state and counters.
    assign fsm_busy         = (state_q == FILL);
    assign mem_read_en      = fsm_busy && (req_cnt_q < REQ_DONE);
    assign memory_address   = base_q + 16'({req_cnt_q, 1'b0});
    assign write_data_array = fsm_busy && memory_data_valid;
    assign fill_address     = base_q + 16'({rsp_cnt_q, 1'b0});
    assign fill_data        = memory_data;
    assign write_tag_array  = write_data_array && (rsp_cnt_q == RSP_LAST);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d   = FILL;
                    base_d    = miss_address & ~OFF_MASK;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            FILL: begin
                if (mem_read_en) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (memory_data_valid) begin
                    if (rsp_cnt_q == RSP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        rsp_cnt_d = rsp_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: 4-cycle pipelined memory model plus event logs compared against expected fill timelines.
module tb_cache_fill_fsm;
    localparam int WORDS = 8;
    localparam int OFF_W = 3;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm #(.WORDS(WORDS), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
        .write_data_array(write_data_array), .fill_address(fill_address),
        .fill_data(fill_data), .write_tag_array(write_tag_array)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [15:0] salt;

    // memory model state
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    int          hold = 0;
    bit          gap_arm = 0;
    int          delivered = 0;
    bit          spur = 0;
    bit          presenting = 0;

    // observation logs
    logic [15:0] req_addr[$];
    int          req_cyc[$];
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          tag_cyc[$];
    int          busy_cyc[$];

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ salt;
    endfunction

    function automatic void clear_logs();
        req_addr.delete(); req_cyc.delete();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        tag_cyc.delete(); busy_cyc.delete();
        delivered = 0;
    endfunction

    function automatic void drive_mem();
        presenting = 0;
        if (hold > 0) hold--;
        else if (pend_addr.size() > 0 && pend_due[0] <= cyc) presenting = 1;
        memory_data_valid = presenting | spur;
        if (presenting) memory_data = mem_val(pend_addr[0]);
        else memory_data = 16'($urandom);
    endfunction

    task automatic tick();
        @(negedge clk);
        if (fsm_busy) busy_cyc.push_back(cyc);
        if (mem_read_en) begin
            req_addr.push_back(memory_address); req_cyc.push_back(cyc);
            pend_addr.push_back(memory_address); pend_due.push_back(cyc + LAT);
        end
        if (write_data_array) begin
            wr_addr.push_back(fill_address); wr_data.push_back(fill_data); wr_cyc.push_back(cyc);
        end
        if (write_tag_array) tag_cyc.push_back(cyc);
        if (presenting) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            delivered++;
            if (gap_arm && delivered == 3) begin
                hold = 3;
                gap_arm = 0;
            end
        end
        @(posedge clk);
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic start_fill(input logic [15:0] a);
        clear_logs();
        t0 = cyc;
        miss_detected = 1'b1;
        miss_address  = a;
        tick();
        miss_detected = 1'b0;
        miss_address  = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000", {fsm_busy, mem_read_en, write_data_array, write_tag_array});
        end
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] base;
        base = 16'h1234 & 16'hFFF0;
        start_fill(16'h1234);
        repeat (17) tick();
        checks++;
        if (req_addr.size() != WORDS || wr_addr.size() != WORDS) begin
            errors++;
            $display("FAIL basic_counts got req %0d wr %0d exp %0d", req_addr.size(), wr_addr.size(), WORDS);
        end else begin
            checks++;
            if (req_addr[0] !== 16'h1230) begin
                errors++; $display("FAIL basic_base got %h exp 1230", req_addr[0]);
            end
            for (int i = 0; i < WORDS; i++) begin
                checks++;
                if (req_addr[i] !== base + 16'(2 * i) || req_cyc[i] != t0 + 1 + i) begin
                    errors++;
                    $display("FAIL basic_req[%0d] got %h@%0d exp %h@%0d", i, req_addr[i], req_cyc[i] - t0, base + 16'(2 * i), 1 + i);
                end
                checks++;
                if (wr_addr[i] !== base + 16'(2 * i) || wr_data[i] !== mem_val(base + 16'(2 * i)) || wr_cyc[i] != t0 + 5 + i) begin
                    errors++;
                    $display("FAIL basic_wr[%0d] got %h/%h@%0d exp %h/%h@%0d", i, wr_addr[i], wr_data[i], wr_cyc[i] - t0,
                             base + 16'(2 * i), mem_val(base + 16'(2 * i)), 5 + i);
                end
            end
        end
        checks++;
        if (tag_cyc.size() != 1 || tag_cyc[0] != t0 + 12) begin
            errors++; $display("FAIL basic_tag got %0d pulses first@%0d exp 1@12", tag_cyc.size(), tag_cyc.size() ? tag_cyc[0] - t0 : -1);
        end
        checks++;
        if (busy_cyc.size() != 12 || busy_cyc[0] != t0 + 1 || busy_cyc[11] != t0 + 12) begin
            errors++; $display("FAIL basic_busy got %0d cycles exp 12 (cycles 1-12)", busy_cyc.size());
        end
    endtask

    task automatic test_wrap();
        start_fill(16'hFFFF);
        repeat (17) tick();
        checks++;
        if (req_addr.size() != WORDS || wr_addr.size() != WORDS) begin
            errors++; $display("FAIL wrap_counts got req %0d wr %0d exp %0d", req_addr.size(), wr_addr.size(), WORDS);
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                checks++;
                if (req_addr[i] !== 16'hFFF0 + 16'(2 * i) || wr_addr[i] !== 16'hFFF0 + 16'(2 * i)) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d] got req %h wr %h exp %h", i, req_addr[i], wr_addr[i], 16'hFFF0 + 16'(2 * i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, a2;
        a1 = 16'($urandom);
        a2 = 16'($urandom);
        clear_logs();
        t0 = cyc;
        miss_detected = 1'b1;
        miss_address  = a1;
        tick();
        miss_address  = a2;
        while (cyc < t0 + 21) tick();
        miss_detected = 1'b0;
        while (cyc < t0 + 32) tick();
        checks++;
        if (req_addr.size() != 2 * WORDS) begin
            errors++; $display("FAIL b2b_req_count got %0d exp %0d", req_addr.size(), 2 * WORDS);
        end else begin
            checks++;
            if (req_addr[0] !== (a1 & 16'hFFF0) || req_cyc[0] != t0 + 1) begin
                errors++; $display("FAIL b2b_first got %h@%0d exp %h@1", req_addr[0], req_cyc[0] - t0, a1 & 16'hFFF0);
            end
            checks++;
            if (req_addr[WORDS] !== (a2 & 16'hFFF0) || req_cyc[WORDS] != t0 + 14) begin
                errors++; $display("FAIL b2b_second got %h@%0d exp %h@14", req_addr[WORDS], req_cyc[WORDS] - t0, a2 & 16'hFFF0);
            end
        end
        checks++;
        if (tag_cyc.size() != 2 || tag_cyc[0] != t0 + 12 || tag_cyc[1] != t0 + 25) begin
            errors++; $display("FAIL b2b_tags got %0d pulses exp 2 at 12,25", tag_cyc.size());
        end
        checks++;
        if (busy_cyc.size() != 24) begin
            errors++; $display("FAIL b2b_busy got %0d cycles exp 24", busy_cyc.size());
        end
    endtask

    task automatic test_gap();
        logic [15:0] a, base;
        a = 16'($urandom);
        base = a & 16'hFFF0;
        gap_arm = 1;
        start_fill(a);
        repeat (20) tick();
        checks++;
        if (wr_addr.size() != WORDS) begin
            errors++; $display("FAIL gap_wr_count got %0d exp %0d", wr_addr.size(), WORDS);
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                checks++;
                if (wr_addr[i] !== base + 16'(2 * i) || wr_data[i] !== mem_val(base + 16'(2 * i)) ||
                    wr_cyc[i] != t0 + ((i < 3) ? 5 + i : 8 + i)) begin
                    errors++;
                    $display("FAIL gap_wr[%0d] got %h/%h@%0d exp %h/%h@%0d", i, wr_addr[i], wr_data[i], wr_cyc[i] - t0,
                             base + 16'(2 * i), mem_val(base + 16'(2 * i)), (i < 3) ? 5 + i : 8 + i);
                end
            end
        end
        checks++;
        if (tag_cyc.size() != 1 || tag_cyc[0] != t0 + 15) begin
            errors++; $display("FAIL gap_tag got %0d pulses exp 1@15", tag_cyc.size());
        end
        checks++;
        if (busy_cyc.size() != 15) begin
            errors++; $display("FAIL gap_busy got %0d cycles exp 15", busy_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        start_fill(16'h2468);
        while (cyc < t0 + 7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b exp 0000", {fsm_busy, mem_read_en, write_data_array, write_tag_array});
        end
        repeat (6) tick();
        checks++;
        if (tag_cyc.size() != 0 || wr_addr.size() != 3) begin
            errors++; $display("FAIL rst_mid_writes got tag %0d wr %0d exp tag 0 wr 3", tag_cyc.size(), wr_addr.size());
        end
        start_fill(16'h0040);
        repeat (17) tick();
        checks++;
        if (req_addr.size() != WORDS || wr_addr.size() != WORDS) begin
            errors++; $display("FAIL rst_refill_counts got req %0d wr %0d exp %0d", req_addr.size(), wr_addr.size(), WORDS);
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                checks++;
                if (wr_addr[i] !== 16'h0040 + 16'(2 * i) || wr_data[i] !== mem_val(16'h0040 + 16'(2 * i))) begin
                    errors++; $display("FAIL rst_refill_wr[%0d] got %h/%h exp %h", i, wr_addr[i], wr_data[i], 16'h0040 + 16'(2 * i));
                end
            end
        end
        checks++;
        if (tag_cyc.size() != 1 || tag_cyc[0] != t0 + 12) begin
            errors++; $display("FAIL rst_refill_tag got %0d pulses exp 1@12", tag_cyc.size());
        end
    endtask

    task automatic test_idle_valid();
        clear_logs();
        spur = 1;
        memory_data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (write_data_array !== 1'b0 || fsm_busy !== 1'b0 || write_tag_array !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid[%0d] got wr %b busy %b tag %b exp 0 0 0", i, write_data_array, fsm_busy, write_tag_array);
            end
            tick();
        end
        spur = 0;
        tick();
        checks++;
        if (busy_cyc.size() != 0 || wr_addr.size() != 0) begin
            errors++; $display("FAIL idle_valid_log got busy %0d wr %0d exp 0 0", busy_cyc.size(), wr_addr.size());
        end
    endtask

    initial begin
        salt = 16'($urandom);
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = 16'h0;
        memory_data_valid = 1'b0;
        memory_data = 16'h0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_idle_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss handler between the L1 caches (I-cache and D-cache data/tag arrays) and the 4-cycle pipelined main memory. On a cache miss it latches the block address and issues one read per word of the 16-byte block on consecutive cycles. It writes each returning word into the data array and pulses the tag-array write once the last word lands. While it runs, `fsm_busy` feeds the pipeline stall logic (`cstall`).

## Interface
Parameters:
- `WORDS`, 8: 16-bit words per block. Must be a power of two; block size is 2·WORDS bytes.
- `OFF_W`, 3: word-offset width, log2(WORDS).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `miss_detected`  in  1  cache lookup missed this cycle. Sampled only in IDLE.
- `miss_address`  in  16  byte address of the missing access. Bits [OFF_W:0] are ignored.
- `memory_data_valid`  in  1  `memory_data` holds the word for the oldest outstanding request.
- `memory_data`  in  16  read data from main memory.
- `fsm_busy`  out  1  fill in progress. Cache control stalls on `miss_detected | fsm_busy`.
- `mem_read_en`  out  1  read request to main memory this cycle.
- `memory_address`  out  16  request address, valid when `mem_read_en` = 1.
- `write_data_array`  out  1  write `fill_data` to the data array at `fill_address` this cycle.
- `fill_address`  out  16  word address for the data-array write.
- `fill_data`  out  16  combinational copy of `memory_data`.
- `write_tag_array`  out  1  one-cycle pulse that writes the tag and sets the valid bit for the block at `fill_address`.

## Operation
- States: IDLE and FILL. Internal registers:
  - `base` (16 bits, low OFF_W+1 bits zero).
  - `req_cnt` (0..WORDS).
  - `rsp_cnt` (0..WORDS-1).
- IDLE → FILL when `miss_detected` = 1. On that edge:
  - `base` ← `miss_address` with bits [OFF_W:0] cleared.
  - `req_cnt` ← 0 and `rsp_cnt` ← 0.
- FILL requests:
  - `mem_read_en` = 1 while `req_cnt` < WORDS.
  - `memory_address` = `base` + 2·`req_cnt`.
  - `req_cnt` increments each requesting cycle and saturates at WORDS.
- FILL responses:
  - `write_data_array` = `memory_data_valid`.
  - `fill_address` = `base` + 2·`rsp_cnt`.
  - `rsp_cnt` increments on each valid response.
- Final response: when `memory_data_valid` = 1 with `rsp_cnt` = WORDS-1, then `write_tag_array` = 1 in the same cycle and the next state is IDLE.
- `fsm_busy` = (state == FILL), decoded from the registered state.
- In IDLE:
  - `memory_data_valid` is ignored.
  - All write/request outputs are 0.
  - `memory_address` and `fill_address` are don't-care.
- `miss_detected` asserted during FILL is ignored. The stalled pipeline re-presents the access after the fill, and it then hits.
- Requests are strictly in order; responses are assumed to be in request order.
- Word order is always 0..WORDS-1. There is no critical-word-first.
- Address arithmetic is 16-bit. A block at 0xFFF0 reaches 0xFFFE with no wrap past the block.

## Timing
- Reset values:
  - State IDLE, `req_cnt` = `rsp_cnt` = 0, `base` = 0.
  - All 1-bit outputs 0.
- Reset wins over every other event, including mid-fill. State returns to IDLE at the next edge and partial writes already made stay in the data array. The tag is never written, so the block remains invalid. Main memory shares `rst`, so no stale responses arrive afterwards.
- Reference timeline with WORDS = 8 and memory latency 4, miss seen at cycle 0 (IDLE):
  - Cycles 1–12: `fsm_busy` = 1.
  - Cycles 1–8: requests for words 0–7.
  - Cycles 5–12: `write_data_array`.
  - Cycle 12: `write_tag_array`.
  - Cycle 13: IDLE, `fsm_busy` = 0.
- A miss asserted in cycle 13 is accepted. The minimum gap between fills is one IDLE cycle.
- Gaps in `memory_data_valid` extend FILL. There is no timeout.

## Test plan
- Reset, then miss at 0x1234 → `base` = 0x1230.
  - Requests 0x1230, 0x1232, …, 0x123E on cycles 1–8.
  - Data-array writes at the same addresses on cycles 5–12.
  - `write_tag_array` only on cycle 12; `fsm_busy` low again on cycle 13.
- Miss at 0xFFFF → requests 0xFFF0 through 0xFFFE, with no carry into or out of the block.
- `miss_detected` held high from cycle 0 through cycle 20 → second fill starts at cycle 13 with a freshly latched address. No request is issued in cycle 13.
- Response gaps: deassert `memory_data_valid` for 3 cycles after word 2 → exactly 8 data writes in order, the tag pulse on the last one, and `fsm_busy` extended by 3 cycles.
- `rst` asserted at cycle 7 of a fill → cycle 8 shows IDLE with all outputs 0 and no `write_tag_array`. A new miss at 0x0040 then fills cleanly.
- `memory_data_valid` = 1 while IDLE → no `write_data_array` and no state change.
